// File: rtl/busy_table_if.sv
// Busy-table port bundle: rename allocations, issue wakeups, operand lookups
// and the registered busy count.
interface busy_table_if #(
    parameter int PRF_W      = 6,
    parameter int RD_PORTS   = 10,
    parameter int WAKE_PORTS = 4
);
    logic                                  flush;
    logic [1:0]                            alloc_en;
    logic [1:0][PRF_W-1:0]                 alloc_num;
    logic [WAKE_PORTS-1:0]                 wake_en;
    logic [WAKE_PORTS-1:0][PRF_W-1:0]      wake_num;
    logic [RD_PORTS-1:0][PRF_W-1:0]        scoreboard_rd_num_l;
    logic [RD_PORTS-1:0][PRF_W-1:0]        scoreboard_rd_num_r;
    logic [RD_PORTS-1:0]                   busyvec_l;
    logic [RD_PORTS-1:0]                   busyvec_r;
    logic [PRF_W:0]                        busy_count;

    modport master (
        output flush, alloc_en, alloc_num, wake_en, wake_num,
               scoreboard_rd_num_l, scoreboard_rd_num_r,
        input  busyvec_l, busyvec_r, busy_count
    );

    modport slave (
        input  flush, alloc_en, alloc_num, wake_en, wake_num,
               scoreboard_rd_num_l, scoreboard_rd_num_r,
        output busyvec_l, busyvec_r, busy_count
    );
endinterface

// File: rtl/busy_table.sv
// Physical-register busy table: one bit per PRF entry, set on rename alloc,
// cleared on wakeup, with a same-cycle wakeup bypass on every lookup port.
module busy_lookup_lane #(
    parameter int PRF_NUM    = 64,
    parameter int PRF_W      = 6,
    parameter int WAKE_PORTS = 4
) (
    input  logic [PRF_NUM-1:0]               busy_q,
    input  logic                             flush,
    input  logic [WAKE_PORTS-1:0]            wake_en,
    input  logic [WAKE_PORTS-1:0][PRF_W-1:0] wake_num,
    input  logic [PRF_W-1:0]                 rd_num_l,
    input  logic [PRF_W-1:0]                 rd_num_r,
    output logic                             busy_l,
    output logic                             busy_r
);
    logic hit_l, hit_r;

    always_comb begin
        hit_l = 1'b0;
        hit_r = 1'b0;
        for (int j = 0; j < WAKE_PORTS; j++) begin
            if (wake_en[j] && wake_num[j] == rd_num_l) hit_l = 1'b1;
            if (wake_en[j] && wake_num[j] == rd_num_r) hit_r = 1'b1;
        end
    end

    // Allocations are deliberately not forwarded; only wakeups bypass.
    assign busy_l = !flush && busy_q[rd_num_l] && !hit_l;
    assign busy_r = !flush && busy_q[rd_num_r] && !hit_r;
endmodule

module busy_table #(
    parameter int PRF_NUM    = 64,
    parameter int PRF_W      = 6,
    parameter int RD_PORTS   = 10,
    parameter int WAKE_PORTS = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    busy_table_if.slave bus
);
    logic [PRF_NUM-1:0] busy_q, busy_d;
    logic [PRF_W:0]     count_q;

    function automatic logic [PRF_W:0] popcnt(input logic [PRF_NUM-1:0] v);
        logic [PRF_W:0] c;
        c = '0;
        for (int i = 0; i < PRF_NUM; i++) c = c + {{PRF_W{1'b0}}, v[i]};
        return c;
    endfunction

    // Clear first, then set, so an alloc beats a wake on the same register.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < WAKE_PORTS; j++)
            if (bus.wake_en[j]) busy_d[bus.wake_num[j]] = 1'b0;
        for (int k = 0; k < 2; k++)
            if (bus.alloc_en[k]) busy_d[bus.alloc_num[k]] = 1'b1;
        busy_d[0] = 1'b0;
        if (bus.flush) busy_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= popcnt(busy_d);
        end
    end

    assign bus.busy_count = count_q;

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_lane
        busy_lookup_lane #(
            .PRF_NUM   (PRF_NUM),
            .PRF_W     (PRF_W),
            .WAKE_PORTS(WAKE_PORTS)
        ) u_lane (
            .busy_q   (busy_q),
            .flush    (bus.flush),
            .wake_en  (bus.wake_en),
            .wake_num (bus.wake_num),
            .rd_num_l (bus.scoreboard_rd_num_l[i]),
            .rd_num_r (bus.scoreboard_rd_num_r[i]),
            .busy_l   (bus.busyvec_l[i]),
            .busy_r   (bus.busyvec_r[i])
        );
    end
endmodule

// File: tb/tb_busy_table.sv
// Random + directed bench for busy_table against a set-of-busy-registers model.
module tb_busy_table;
    localparam int PRF_NUM = 64, PRF_W = 6, RD_PORTS = 10, WAKE_PORTS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0, bad = 0;
    bit   chk_en = 1'b0;
    bit   narrow;
    bit [PRF_NUM-1:0] mbusy;

    busy_table_if #(.PRF_W(PRF_W), .RD_PORTS(RD_PORTS), .WAKE_PORTS(WAKE_PORTS)) bus ();

    busy_table #(.PRF_NUM(PRF_NUM), .PRF_W(PRF_W), .RD_PORTS(RD_PORTS),
                 .WAKE_PORTS(WAKE_PORTS))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next set of busy registers from the current one and this cycle's inputs.
    function automatic bit [PRF_NUM-1:0] model_next();
        bit [PRF_NUM-1:0] s = mbusy;
        if (bus.flush) return '0;
        for (int j = 0; j < WAKE_PORTS; j++)
            if (bus.wake_en[j]) s[bus.wake_num[j]] = 1'b0;
        for (int k = 0; k < 2; k++)
            if (bus.alloc_en[k] && bus.alloc_num[k] != 0) s[bus.alloc_num[k]] = 1'b1;
        return s;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < PRF_NUM; i++) c += mbusy[i];
        return c;
    endfunction

    function automatic int exp_lookup(input logic [PRF_W-1:0] a);
        if (!rst_n || bus.flush) return 0;
        for (int j = 0; j < WAKE_PORTS; j++)
            if (bus.wake_en[j] && bus.wake_num[j] == a) return 0;
        return int'(mbusy[a]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mbusy <= '0;
        else        mbusy <= model_next();
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            for (int i = 0; i < RD_PORTS; i++) begin
                chk($sformatf("busyvec_l[%0d]", i), int'(bus.busyvec_l[i]),
                    exp_lookup(bus.scoreboard_rd_num_l[i]));
                chk($sformatf("busyvec_r[%0d]", i), int'(bus.busyvec_r[i]),
                    exp_lookup(bus.scoreboard_rd_num_r[i]));
            end
            chk("busy_count", int'(bus.busy_count), model_count());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush    = 1'b0;
        bus.alloc_en = '0;
        bus.wake_en  = '0;
    endtask

    function automatic logic [PRF_W-1:0] pick();
        return narrow ? PRF_W'($urandom_range(0, 15)) : PRF_W'($urandom_range(0, PRF_NUM-1));
    endfunction

    task automatic rand_inputs();
        narrow       = ($urandom_range(0, 1) == 1);
        bus.flush    = ($urandom_range(0, 31) == 0);
        bus.alloc_en = 2'($urandom);
        for (int k = 0; k < 2; k++) bus.alloc_num[k] = pick();
        bus.wake_en  = WAKE_PORTS'($urandom);
        for (int j = 0; j < WAKE_PORTS; j++) bus.wake_num[j] = pick();
        for (int i = 0; i < RD_PORTS; i++) begin
            bus.scoreboard_rd_num_l[i] = pick();
            bus.scoreboard_rd_num_r[i] = pick();
        end
    endtask

    initial begin
        idle();
        bus.alloc_num = '0;
        bus.wake_num  = '0;
        bus.scoreboard_rd_num_l = '0;
        bus.scoreboard_rd_num_r = '0;
        #3;
        for (int i = 0; i < RD_PORTS; i++) bus.scoreboard_rd_num_l[i] = PRF_W'(i + 1);
        #8;
        chk("reset busy_count", int'(bus.busy_count), 0);
        chk("reset busyvec_l", int'(bus.busyvec_l), 0);
        chk("reset busyvec_r", int'(bus.busyvec_r), 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Alloc of 5 becomes visible one cycle later.
        cyc(); idle();
        bus.alloc_en = 2'b01; bus.alloc_num[0] = 6'd5; bus.scoreboard_rd_num_l[0] = 6'd5;
        @(negedge clk); chk("alloc same-cycle l0", int'(bus.busyvec_l[0]), 0);
        cyc(); idle();
        @(negedge clk); chk("alloc next l0", int'(bus.busyvec_l[0]), 1);
        chk("alloc next count", int'(bus.busy_count), 1);

        // Wake 5 on port 2 bypasses to r[9] the same cycle.
        cyc(); idle();
        bus.wake_en = 4'b0100; bus.wake_num[2] = 6'd5; bus.scoreboard_rd_num_r[9] = 6'd5;
        @(negedge clk); chk("wake same-cycle r9", int'(bus.busyvec_r[9]), 0);
        cyc(); idle();
        @(negedge clk); chk("wake next r9", int'(bus.busyvec_r[9]), 0);
        chk("wake next count", int'(bus.busy_count), 0);
        cyc();
        @(negedge clk); chk("wake later r9", int'(bus.busyvec_r[9]), 0);

        // Wake and alloc of 7 in the same cycle: reads 0 now, busy after.
        cyc(); idle();
        bus.alloc_en = 2'b01; bus.alloc_num[0] = 6'd7;
        cyc(); idle();
        bus.scoreboard_rd_num_l[1] = 6'd7;
        bus.wake_en = 4'b0001; bus.wake_num[0] = 6'd7;
        bus.alloc_en = 2'b01; bus.alloc_num[0] = 6'd7;
        @(negedge clk); chk("wake+alloc same l1", int'(bus.busyvec_l[1]), 0);
        cyc(); idle();
        @(negedge clk); chk("wake+alloc next l1", int'(bus.busyvec_l[1]), 1);
        cyc(); idle();
        bus.wake_en = 4'b1000; bus.wake_num[3] = 6'd7;

        // Flush with allocs pending wipes everything.
        cyc(); idle();
        bus.alloc_en = 2'b11; bus.alloc_num[0] = 6'd3; bus.alloc_num[1] = 6'd9;
        cyc(); idle();
        bus.alloc_en = 2'b01; bus.alloc_num[0] = 6'd40;
        cyc(); idle();
        bus.flush = 1'b1; bus.alloc_en = 2'b11; bus.alloc_num[0] = 6'd11; bus.alloc_num[1] = 6'd12;
        bus.scoreboard_rd_num_l[0] = 6'd3; bus.scoreboard_rd_num_l[1] = 6'd9;
        bus.scoreboard_rd_num_l[2] = 6'd40;
        bus.scoreboard_rd_num_r[0] = 6'd3; bus.scoreboard_rd_num_r[1] = 6'd9;
        bus.scoreboard_rd_num_r[2] = 6'd40;
        @(negedge clk);
        chk("flush count before", int'(bus.busy_count), 3);
        chk("flush busyvec_l", int'(bus.busyvec_l), 0);
        chk("flush busyvec_r", int'(bus.busyvec_r), 0);
        cyc(); idle();
        @(negedge clk);
        chk("flush next count", int'(bus.busy_count), 0);
        chk("flush next l2", int'(bus.busyvec_l[2]), 0);

        // Register 0 never becomes busy.
        cyc(); idle();
        bus.alloc_en = 2'b11; bus.alloc_num[0] = 6'd0; bus.alloc_num[1] = 6'd20;
        cyc(); idle();
        bus.scoreboard_rd_num_l[0] = 6'd0; bus.scoreboard_rd_num_l[1] = 6'd20;
        @(negedge clk);
        chk("reg0 l0", int'(bus.busyvec_l[0]), 0);
        chk("reg0 l1", int'(bus.busyvec_l[1]), 1);
        chk("reg0 count", int'(bus.busy_count), 1);
        cyc(); idle();
        bus.wake_en = 4'b0011; bus.wake_num[0] = 6'd20; bus.wake_num[1] = 6'd20;
        cyc(); idle();
        @(negedge clk); chk("dup wake count", int'(bus.busy_count), 0);

        for (int n = 0; n < 2000; n++) begin
            cyc();
            rand_inputs();
        end

        // Fill 20 registers, then pulse reset between edges.
        cyc(); idle(); bus.flush = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cyc(); idle();
            bus.alloc_en = 2'b11;
            bus.alloc_num[0] = PRF_W'(2*n + 1);
            bus.alloc_num[1] = PRF_W'(2*n + 2);
        end
        cyc(); idle();
        for (int i = 0; i < RD_PORTS; i++) begin
            bus.scoreboard_rd_num_l[i] = PRF_W'(i + 1);
            bus.scoreboard_rd_num_r[i] = PRF_W'(i + 11);
        end
        @(negedge clk);
        chk("fill20 count", int'(bus.busy_count), 20);
        chk("fill20 busyvec_l", int'(bus.busyvec_l), (1 << RD_PORTS) - 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset count", int'(bus.busy_count), 0);
        chk("midreset busyvec_l", int'(bus.busyvec_l), 0);
        chk("midreset busyvec_r", int'(bus.busyvec_r), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("postreset count", int'(bus.busy_count), 0);

        for (int n = 0; n < 300; n++) begin
            cyc();
            rand_inputs();
        end
        cyc(); idle();
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/busy_table.md
BUSY_TABLE -- requirements
Module: busy_table

Interface

REQ-001 The block SHALL have parameter PRF_NUM, default 64, giving the number of physical registers.
REQ-002 The block SHALL have parameter PRF_W, default 6, giving the width of a PRFNum (log2 PRF_NUM).
REQ-003 The block SHALL have parameter RD_PORTS, default 10, giving the number of operand-pair lookup ports (entries 0..7 are queue slots, 8..9 are incoming dispatch).
REQ-004 The block SHALL have parameter WAKE_PORTS, default 4, giving the number of wakeup/clear ports.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port flush, input, 1 bit: pipeline flush, synchronous.
REQ-008 The block SHALL have port alloc_en, input, 2 bits: rename allocates destination k this cycle.
REQ-009 The block SHALL have port alloc_num, input, 2 x PRF_W: allocated destination PRFNums.
REQ-010 The block SHALL have port wake_en, input, WAKE_PORTS bits: issue-side wakeup valid (ALU0, ALU1, MDU, LSU).
REQ-011 The block SHALL have port wake_num, input, WAKE_PORTS x PRF_W: woken PRFNums.
REQ-012 The block SHALL have port scoreboard_rd_num_l, input, RD_PORTS x PRF_W: left-operand lookup addresses.
REQ-013 The block SHALL have port scoreboard_rd_num_r, input, RD_PORTS x PRF_W: right-operand lookup addresses.
REQ-014 The block SHALL have port busyvec_l, output, RD_PORTS bits: busy status per left lookup.
REQ-015 The block SHALL have port busyvec_r, output, RD_PORTS bits: busy status per right lookup.
REQ-016 The block SHALL have port busy_count, output, PRF_W+1 bits: number of busy entries, registered.

Function

REQ-017 The block SHALL hold a PRF_NUM-bit register busy_q, one bit per physical register; 1 means the value is not yet produced.
REQ-018 busy_q[0] SHALL be constant 0; alloc or wake targeting register 0 SHALL be ignored.
REQ-019 Next state SHALL be computed in this order: busy_d = busy_q; clear every wake_num[j] with wake_en[j]; then set every alloc_num[k] with alloc_en[k] (set wins over clear on the same register in the same cycle).
REQ-020 When flush=1, busy_d SHALL be all zeros regardless of alloc_en/wake_en in that cycle.
REQ-021 Each lookup SHALL be combinational: busyvec_x[i] = busy_q[addr] AND NOT (any wake_en[j] with wake_num[j]==addr).
REQ-022 Same-cycle alloc SHALL NOT be forwarded to lookups; a newly allocated register reads busy from the next cycle onward.
REQ-023 When flush=1, all busyvec_l/busyvec_r bits SHALL read 0 in that cycle.
REQ-024 Duplicate wake_num values across ports SHALL be legal and equivalent to a single clear.
REQ-025 alloc_num[0]==alloc_num[1] with both enabled SHALL set that one bit once.
REQ-026 busy_count SHALL be registered and equal the popcount of busy_q (one-cycle lag from busy_d), so it never exceeds PRF_NUM-1.
REQ-027 Lookup latency SHALL be 0 cycles; alloc-to-visible latency SHALL be 1 cycle; wake-to-visible latency SHALL be 0 cycles (bypass) and persist from the next cycle onward.

Reset

REQ-028 On rst_n=0, busy_q and busy_count SHALL clear to 0 immediately, independent of clk.
REQ-029 During reset, busyvec_l and busyvec_r SHALL read all zeros.
REQ-030 The first rising edge after rst_n deasserts SHALL apply normal update rules.
REQ-031 Assertion of rst_n mid-operation SHALL discard all pending state with no partial update.

Verification

REQ-032 The bench SHALL cover: alloc_en=01, alloc_num[0]=5 at cycle N, lookup l[0]=5 -> busyvec_l[0]=0 at N, 1 at N+1; busy_count=1 at N+1.
REQ-033 The bench SHALL cover: reg 5 busy, wake_en[2]=1 with wake_num=5, lookup r[9]=5 -> busyvec_r[9]=0 in the same cycle and all later cycles; busy_count=0 next cycle.
REQ-034 The bench SHALL cover: reg 7 busy; same cycle wake 7 and alloc 7 -> busyvec reads 0 that cycle, 1 next cycle.
REQ-035 The bench SHALL cover: regs 3, 9, 40 busy, flush=1 with alloc_en=11 -> all lookups read 0 that cycle; busy_q and busy_count are 0 next cycle.
REQ-036 The bench SHALL cover: alloc of reg 0, then lookup of 0 -> busyvec=0 and busy_count unchanged.
REQ-037 The bench SHALL cover: 20 regs busy, rst_n pulsed low between clock edges -> busy_count=0 and all lookups read 0 before the next clk edge.
